piso_sched: RTL and testbench
=============================

Name: piso_sched

Overview:
- Two-requester scheduler for a shared parallel-in/serial-out shifter.
- Each requester offers a WIDTH-bit word via valid/ready. The block arbitrates round-robin, loads the winner's word, and shifts it out MSB-first with framing strobes.
- It sequences the load/shift controls that a bare PISO needs, so multiple sources can share one serial lane.

Parameters:
WIDTH, 4, parallel word width (>=2)
GAP, 1, idle cycles inserted after each frame before re-arbitration (>=0)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a word
req0_data  input  WIDTH  requester 0 word
req0_ready  output  1  requester 0 word accepted this cycle (combinational)
req1_valid  input  1  requester 1 has a word
req1_data  input  WIDTH  requester 1 word
req1_ready  output  1  requester 1 word accepted this cycle (combinational)
ser_out  output  1  serial data bit, registered
ser_valid  output  1  ser_out carries a data bit, registered
frame_start  output  1  one-cycle pulse with first bit of a frame
frame_done  output  1  one-cycle pulse with last bit of a frame
grant_id  output  1  requester owning current/last frame, registered
busy  output  1  high in SHIFT and GAP states
frame_count  output  8  frames completed, wraps 255->0

Behaviour:
- Reset (rst=0, asynchronous) forces the following:
  - state=IDLE; shift register=0; bit counter=0; gap counter=0.
  - rr pointer=0 (requester 0 preferred next).
  - ser_out=0, ser_valid=0, frame_start=0, frame_done=0, grant_id=0, busy=0, frame_count=0.
  - Deassertion is synchronised by the design externally; no internal state survives reset.
- States: IDLE, SHIFT, GAP.
- IDLE arbitration:
  - One valid: that requester wins.
  - Both valid: the requester equal to the rr pointer wins.
  - reqN_ready = (state==IDLE) && winner==N. At most one ready is high at a time.
  - Ready never depends on the other requester's ready.
- Handshake: on a clock edge with valid&&ready, the following happen:
  - Capture reqN_data into the shift register and set grant_id=N.
  - Set rr pointer = ~N, set bit counter=WIDTH-1, and go to SHIFT.
- SHIFT:
  - Each cycle: ser_out=shreg[WIDTH-1], ser_valid=1, busy=1.
  - Shift register shifts left with a 0 fill.
  - Latency: the word accepted at edge k appears as first bit in the cycle after edge k. The frame occupies exactly WIDTH consecutive cycles.
  - frame_start is high during the first bit; frame_done is high during the last bit. Both are high together only if WIDTH==1, which is excluded.
  - After the last bit: frame_count increments (wraps modulo 256). Then go to GAP if GAP>0, else IDLE.
- GAP:
  - ser_valid=0, ser_out=0, busy=1 for GAP cycles, then IDLE.
- Minimum spacing between frames is GAP+1 cycles: the GAP cycles plus the IDLE handshake cycle. ser_valid=0 during the handshake cycle.
- Valid during SHIFT/GAP: ready stays 0 and nothing is captured. The requester must hold valid and data stable until ready.
- A requester dropping valid before ready means no transfer; this is legal.
- Reset mid-frame: the frame is aborted immediately (ser_valid→0), frame_count is unaffected apart from the reset clear, and the word is lost. The requester must re-offer it.
- Data changes on a non-granted requester never affect an in-flight frame. The shift register is the only data source during SHIFT.

Test Plan:
- Reset release; req0_valid=1, req0_data=4'b1010 → req0_ready=1 one cycle. Next 4 cycles: ser_out 1,0,1,0, ser_valid=1, frame_start on cycle 1, frame_done on cycle 4, grant_id=0, frame_count 0→1.
- After reset both valid, req0_data=4'b1101, req1_data=4'b1001 → req0 served first: bits 1,1,0,1. Then 1 GAP cycle and 1 IDLE cycle. Then req1: bits 1,0,0,1, grant_id=1.
- Both valid held continuously for 4 frames → grant order 0,1,0,1. Each pair of frames is separated by exactly 2 cycles with ser_valid=0.
- req1_valid raised with 4'b0110 on bit 2 of a req0 frame → req1_ready stays 0 until the post-GAP IDLE cycle. Then 0,1,1,0 is shifted, and the req0 frame is unaltered.
- rst pulled low after 2 bits of 4'b1011 → ser_valid, busy and frame_count go 0 immediately. After release: IDLE, req0_ready=1 if still valid, and the full word 1,0,1,1 is resent.
- 256 back-to-back single-requester frames → frame_count wraps 255→0 on the 256th frame_done. Arbitration is unaffected.

Source files
------------

// File: rtl/piso_sched.sv
// piso_sched: a round-robin scheduler that lets two valid/ready requesters
// share one parallel-in/serial-out shifter.
// The winner's word is loaded and shifted out MSB-first. Each frame carries a
// frame_start strobe on its first bit and a frame_done strobe on its last bit.
// After each frame the block holds off for GAP idle cycles before it
// arbitrates again.
//
// Handshake: reqN_ready is combinational and can only be high in IDLE. A word
// transfers on the rising edge where reqN_valid && reqN_ready. The requester
// must hold valid and data stable until that edge. Dropping valid earlier is
// legal and means no transfer.
module piso_sched #(
   parameter int WIDTH = 4,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             frame_done,
   output logic             grant_id,
   output logic             busy,
   output logic [7:0]       frame_count,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;     // bits still to be presented, MSB next
   logic [CW-1:0]    bitcnt;    // bits remaining after the one on ser_out
   logic [GW-1:0]    gapcnt;
   logic             rr;        // requester preferred when both are valid
   logic             is_idle;
   logic             win1;
   logic [WIDTH-1:0] win_data;

   // Arbitration: a lone valid requester wins; a tie goes to the rr pointer.
   always_comb begin
      is_idle    = (state == S_IDLE);
      win1       = req1_valid && (!req0_valid || rr);
      req1_ready = is_idle && win1;
      req0_ready = is_idle && req0_valid && !win1;
      win_data   = win1 ? req1_data : req0_data;
      busy       = !is_idle;
      state_dbg  = state;
   end

   // Frame sequencer: load on handshake, shift WIDTH bits, then hold off GAP cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         shreg       <= '0;
         bitcnt      <= '0;
         gapcnt      <= '0;
         rr          <= 1'b0;
         ser_out     <= 1'b0;
         ser_valid   <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         grant_id    <= 1'b0;
         frame_count <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req0_ready || req1_ready) begin
                  // The first bit goes straight to ser_out and the rest stay queued in shreg.
                  ser_out     <= win_data[WIDTH-1];
                  shreg       <= {win_data[WIDTH-2:0], 1'b0};
                  ser_valid   <= 1'b1;
                  frame_start <= 1'b1;
                  frame_done  <= 1'b0;
                  bitcnt      <= CW'(WIDTH - 1);
                  grant_id    <= win1;
                  rr          <= !win1;
                  state       <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               frame_start <= 1'b0;
               if (bitcnt != '0) begin
                  ser_out    <= shreg[WIDTH-1];
                  shreg      <= {shreg[WIDTH-2:0], 1'b0};
                  bitcnt     <= bitcnt - CW'(1);
                  frame_done <= (bitcnt == CW'(1));
               end else begin
                  ser_out     <= 1'b0;
                  ser_valid   <= 1'b0;
                  frame_done  <= 1'b0;
                  frame_count <= frame_count + 8'd1;
                  if (GAP > 0) begin
                     gapcnt <= GW'(GAP - 1);
                     state  <= S_GAP;
                  end else begin
                     state  <= S_IDLE;
                  end
               end
            end
            S_GAP: begin
               if (gapcnt == '0) state <= S_IDLE;
               else              gapcnt <= gapcnt - GW'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_sched.sv
// Directed bench for piso_sched (WIDTH=4, GAP=1).
// Each requester agent sends the words in its source queue, holding valid
// until the word is accepted. A monitor rebuilds every completed frame and
// compares it with the expected word and grant queues.
module tb_piso_sched;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         req0_valid, req1_valid;
   logic [W-1:0] req0_data, req1_data;
   logic         req0_ready, req1_ready;
   logic         ser_out, ser_valid, frame_start, frame_done, grant_id, busy;
   logic [7:0]   frame_count;
   logic [1:0]   state_dbg;

   int           err_cnt = 0;
   int           chk_cnt = 0;

   logic [W-1:0] src0_q[$];
   logic [W-1:0] src1_q[$];
   logic [W-1:0] exp_q[$];
   logic         exp_g_q[$];

   piso_sched #(.WIDTH(W), .GAP(1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start),
      .frame_done(frame_done), .grant_id(grant_id), .busy(busy),
      .frame_count(frame_count), .state_dbg(state_dbg)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", chk_cnt);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // requester 0 agent
   initial begin : agent0
      logic a0;
      logic [W-1:0] tmp0;
      req0_valid = 1'b0;
      req0_data  = '0;
      forever begin
         @(negedge clk);
         a0 = rst && req0_valid && req0_ready;
         @(posedge clk);
         #1;
         if (a0 && src0_q.size() > 0) tmp0 = src0_q.pop_front();
         if (src0_q.size() > 0) begin
            req0_valid = 1'b1;
            req0_data  = src0_q[0];
         end else begin
            req0_valid = 1'b0;
         end
      end
   end

   // requester 1 agent
   initial begin : agent1
      logic a1;
      logic [W-1:0] tmp1;
      req1_valid = 1'b0;
      req1_data  = '0;
      forever begin
         @(negedge clk);
         a1 = rst && req1_valid && req1_ready;
         @(posedge clk);
         #1;
         if (a1 && src1_q.size() > 0) tmp1 = src1_q.pop_front();
         if (src1_q.size() > 0) begin
            req1_valid = 1'b1;
            req1_data  = src1_q[0];
         end else begin
            req1_valid = 1'b0;
         end
      end
   end

   // scoreboard monitor: rebuild each frame and compare with the expected queues
   initial begin : monitor
      logic [W-1:0] mon_word;
      int mon_cnt;
      mon_word = '0;
      mon_cnt  = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            mon_cnt = 0;
         end else if (ser_valid) begin
            mon_word = {mon_word[W-2:0], ser_out};
            mon_cnt++;
            if (frame_done) begin
               if (exp_q.size() == 0) begin
                  check("sb_unexpected_frame", 32'd1, 32'd0);
               end else begin
                  check("sb_word", mon_word, exp_q.pop_front());
                  check("sb_grant", grant_id, exp_g_q.pop_front());
                  check("sb_len", mon_cnt, W);
               end
               mon_cnt = 0;
            end
         end
      end
   end

   task automatic expect_frame(input logic [W-1:0] w, input logic g);
      exp_q.push_back(w);
      exp_g_q.push_back(g);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      src0_q.delete();
      src1_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic next_start(output int idle);
      int t;
      idle = 0;
      t = 0;
      do begin
         @(negedge clk);
         t++;
         if (!frame_start && !ser_valid) idle++;
      end while (!frame_start && t < 20);
      if (!frame_start) check("start_timeout", 32'd0, 32'd1);
   endtask

   task automatic next_done();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!frame_done && t < 20);
      if (!frame_done) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin : main
      logic [W-1:0] w;
      int n;

      // ---- T1: reset state, then a single 1010 frame from requester 0
      rst = 1'b0;
      @(negedge clk);
      check("rst_ser_valid", ser_valid, 0);
      check("rst_ser_out", ser_out, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_grant", grant_id, 0);
      check("rst_start_done", {frame_start, frame_done}, 0);
      check("rst_state", state_dbg, 0);
      src0_q.push_back(4'b1010);
      expect_frame(4'b1010, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("t1_ready0", req0_ready, 1);
      check("t1_ready1", req1_ready, 0);
      check("t1_idle_valid", ser_valid, 0);
      w = 4'b1010;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         check("t1_bit", ser_out, w[W-1-i]);
         check("t1_valid", ser_valid, 1);
         check("t1_start", frame_start, (i == 0));
         check("t1_done", frame_done, (i == W-1));
         check("t1_busy", busy, 1);
         check("t1_ready0_low", req0_ready, 0);
      end
      check("t1_fc_before", frame_count, 0);
      @(negedge clk);
      check("t1_fc_after", frame_count, 1);
      check("t1_gap_valid", ser_valid, 0);
      check("t1_gap_busy", busy, 1);
      check("t1_gap_state", state_dbg, 2);
      @(negedge clk);
      check("t1_idle_busy", busy, 0);
      check("t1_idle_state", state_dbg, 0);

      // ---- T2: both valid after reset, requester 0 first, then requester 1
      do_reset();
      src0_q.push_back(4'b1101);
      src1_q.push_back(4'b1001);
      expect_frame(4'b1101, 1'b0);
      expect_frame(4'b1001, 1'b1);
      @(negedge clk);
      check("t2_ready0", req0_ready, 1);
      check("t2_ready1", req1_ready, 0);
      next_start(n);
      check("t2_latency", n, 0);
      check("t2_grant0", grant_id, 0);
      next_done();
      next_start(n);
      check("t2_spacing", n, 2);
      check("t2_grant1", grant_id, 1);
      next_done();
      @(negedge clk);
      check("t2_fc", frame_count, 2);

      // ---- T3: both held for four frames, alternating grants, 2 idle cycles apart
      do_reset();
      src0_q.push_back(4'b0011);
      src0_q.push_back(4'b1110);
      src1_q.push_back(4'b0101);
      src1_q.push_back(4'b1000);
      expect_frame(4'b0011, 1'b0);
      expect_frame(4'b0101, 1'b1);
      expect_frame(4'b1110, 1'b0);
      expect_frame(4'b1000, 1'b1);
      for (int k = 0; k < 4; k++) begin
         next_start(n);
         if (k > 0) check("t3_spacing", n, 2);
         check("t3_grant", grant_id, k % 2);
         next_done();
      end
      @(negedge clk);
      check("t3_fc", frame_count, 4);

      // ---- T4: requester 1 raises valid mid-frame and waits until the post-GAP IDLE
      do_reset();
      src0_q.push_back(4'b1100);
      expect_frame(4'b1100, 1'b0);
      expect_frame(4'b0110, 1'b1);
      next_start(n);
      src1_q.push_back(4'b0110);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t4_ready1_held", req1_ready, 0);
         check("t4_valid1_up", req1_valid, 1);
      end
      @(negedge clk);
      check("t4_ready1_idle", req1_ready, 1);
      next_start(n);
      check("t4_latency", n, 0);
      check("t4_grant", grant_id, 1);
      next_done();
      @(negedge clk);
      check("t4_fc", frame_count, 2);

      // ---- T5: reset after two bits of 1011; the word is re-offered and resent whole
      src0_q.push_back(4'b1011);
      expect_frame(4'b1011, 1'b0);
      next_start(n);
      @(negedge clk);
      check("t5_pre_fc", frame_count, 2);
      check("t5_pre_valid", ser_valid, 1);
      @(posedge clk);
      #1 rst = 1'b0;
      src0_q.push_back(4'b1011);
      #1;
      check("t5_abort_valid", ser_valid, 0);
      check("t5_abort_busy", busy, 0);
      check("t5_abort_fc", frame_count, 0);
      @(negedge clk);
      check("t5_rst_state", state_dbg, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("t5_ready0", req0_ready, 1);
      next_start(n);
      check("t5_latency", n, 0);
      next_done();
      @(negedge clk);
      check("t5_fc", frame_count, 1);

      // ---- T6: 256 frames from requester 0, frame_count wraps, then a tie goes to requester 1
      do_reset();
      for (int k = 0; k < 256; k++) begin
         w = W'(k) ^ 4'h9;
         src0_q.push_back(w);
         expect_frame(w, 1'b0);
      end
      for (int k = 0; k < 256; k++) begin
         next_done();
         @(negedge clk);
         if (k == 0 || k == 254 || k == 255) check("t6_fc", frame_count, (k + 1) % 256);
      end
      src0_q.push_back(4'b0001);
      src1_q.push_back(4'b1110);
      expect_frame(4'b1110, 1'b1);
      expect_frame(4'b0001, 1'b0);
      next_start(n);
      check("t6_tie_grant1", grant_id, 1);
      next_done();
      next_start(n);
      check("t6_then_grant0", grant_id, 0);
      next_done();

      repeat (4) @(negedge clk);
      check("sb_left", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
